// File: rtl/bb_pwm_pkg.sv
// Shared definitions for the PWM capture path and its generator counterpart.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bb_pwm_pkg;

    localparam int SPEED_W       = 16;
    localparam int MIN_SPEED_DEF = 256;
    localparam int MAX_SPEED_DEF = 65535;

    localparam int ST_WAIT_LOW  = 0;
    localparam int ST_WAIT_RISE = 1;
    localparam int ST_HIGH      = 2;
    localparam int ST_LOW       = 3;

    typedef logic [SPEED_W-1:0] speed_t;

    function automatic speed_t sat_inc(speed_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bb_pwm_capture_if.sv
// Pin input and measurement outputs of the PWM capture block.
// Latency: n/a (wiring only).
// Backpressure: none; speed_oe is a fire-and-forget strobe.
interface bb_pwm_capture_if;
    import bb_pwm_pkg::*;

    logic       pwm_in;
    speed_t     speed_out;
    logic       speed_oe;
    speed_t     period_out;
    logic       lost;
    logic [7:0] glitch_cnt;
    logic       busy;

    modport master (input pwm_in,
                    output speed_out, speed_oe, period_out, lost, glitch_cnt, busy);
    modport slave  (output pwm_in,
                    input speed_out, speed_oe, period_out, lost, glitch_cnt, busy);
endinterface

// File: rtl/bb_pwm_sync_edge.sv
// Two-flop synchronizer for the raw pin plus a delay flop for edge detection.
// Latency: level 2 cycles after the pin, rise/fall combinational from level.
// Backpressure: none.
module bb_pwm_sync_edge (
    input  logic clk,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    // Left unreset on purpose: a short reset mid-pulse must still see the pin
    // high afterwards, so the interrupted pulse cannot pose as a new rise.
    always_ff @(posedge clk) begin
        s1 <= din;
        s2 <= s1;
        s3 <= s2;
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
endmodule

// File: rtl/bb_pwm_capture.sv
// Measures PWM high time/period in clk cycles; BB_PWM_CAPTURE_AVG_EN adds a 4-sample average.
// Latency: speed_oe 3 edges after the pin falls (4 with averaging).
// Backpressure: none; consumer must take speed_out on the speed_oe strobe.
module bb_pwm_capture
    import bb_pwm_pkg::*;
#(
    parameter int MIN_SPEED   = MIN_SPEED_DEF,
    parameter int MAX_SPEED   = MAX_SPEED_DEF,
    parameter int TIMEOUT     = 1000000,
    parameter int TO_WIDTH    = 20,
    parameter int STATE_WIDTH = 3
) (
    input  logic clk,
    input  logic rst,
    bb_pwm_capture_if.master cap
);
    localparam logic [STATE_WIDTH-1:0] WAIT_LOW  = STATE_WIDTH'(ST_WAIT_LOW);
    localparam logic [STATE_WIDTH-1:0] WAIT_RISE = STATE_WIDTH'(ST_WAIT_RISE);
    localparam logic [STATE_WIDTH-1:0] HIGH      = STATE_WIDTH'(ST_HIGH);
    localparam logic [STATE_WIDTH-1:0] LOW       = STATE_WIDTH'(ST_LOW);
    localparam logic [TO_WIDTH-1:0]    TO_MAX    = TO_WIDTH'(TIMEOUT);

    logic                   level, rise, fall;
    logic [STATE_WIDTH-1:0] state;
    speed_t                 width_cnt, per_cnt, period_q, speed_q;
    logic [TO_WIDTH-1:0]    to_cnt;
    logic                   lost_q, oe_q;
    logic [7:0]             glitch_q;
    logic                   timeout, in_range, accept;

    bb_pwm_sync_edge u_sync (
        .clk   (clk),
        .din   (cap.pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign timeout  = (state != WAIT_LOW) && (to_cnt == TO_MAX);
    assign in_range = (32'(width_cnt) >= MIN_SPEED) && (32'(width_cnt) <= MAX_SPEED);
    assign accept   = (state == HIGH) && fall && !timeout && in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_LOW;
            width_cnt <= '0;
            per_cnt   <= '0;
            to_cnt    <= '0;
            period_q  <= '0;
            lost_q    <= 1'b1;
            glitch_q  <= '0;
        end else begin
            per_cnt <= sat_inc(per_cnt);
            if (rise || fall)
                to_cnt <= '0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + 1'b1;

            // Timeout outranks any edge seen in the same cycle.
            if (timeout) begin
                lost_q <= 1'b1;
                state  <= WAIT_LOW;
                to_cnt <= '0;
            end else begin
                case (state)
                    WAIT_LOW: if (!level) state <= WAIT_RISE;
                    WAIT_RISE: if (rise) begin
                        width_cnt <= 16'd1;
                        per_cnt   <= 16'd1;
                        state     <= HIGH;
                    end
                    HIGH: begin
                        if (fall) begin
                            state <= LOW;
                            if (in_range)
                                lost_q <= 1'b0;
                            else if (glitch_q != 8'hFF)
                                glitch_q <= glitch_q + 8'd1;
                        end else begin
                            width_cnt <= sat_inc(width_cnt);
                        end
                    end
                    LOW: if (rise) begin
                        period_q  <= per_cnt;
                        per_cnt   <= 16'd1;
                        width_cnt <= 16'd1;
                        state     <= HIGH;
                    end
                    default: state <= WAIT_LOW;
                endcase
            end
        end
    end

`ifdef BB_PWM_CAPTURE_AVG_EN
    speed_t      win [4];
    logic [2:0]  fill;
    logic        avg_pend;
    logic [17:0] sum;

    assign sum = 18'(win[0]) + 18'(win[1]) + 18'(win[2]) + 18'(win[3]);

    // Window restarts whenever lost asserts, so a stale average never leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) win[i] <= '0;
            fill     <= '0;
            avg_pend <= 1'b0;
            speed_q  <= 16'(MIN_SPEED);
            oe_q     <= 1'b0;
        end else begin
            oe_q <= 1'b0;
            if (timeout) begin
                for (int i = 0; i < 4; i++) win[i] <= '0;
                fill     <= '0;
                avg_pend <= 1'b0;
            end else begin
                avg_pend <= accept && (fill >= 3'd3);
                if (accept) begin
                    win[3] <= win[2];
                    win[2] <= win[1];
                    win[1] <= win[0];
                    win[0] <= width_cnt;
                    if (fill != 3'd4) fill <= fill + 3'd1;
                end
                if (avg_pend) begin
                    speed_q <= speed_t'(sum >> 2);
                    oe_q    <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            speed_q <= 16'(MIN_SPEED);
            oe_q    <= 1'b0;
        end else begin
            oe_q <= accept;
            if (accept) speed_q <= width_cnt;
        end
    end
`endif

    assign cap.speed_out  = speed_q;
    assign cap.speed_oe   = oe_q;
    assign cap.period_out = period_q;
    assign cap.lost       = lost_q;
    assign cap.glitch_cnt = glitch_q;
    assign cap.busy       = (state == HIGH);
endmodule

// File: doc/bb_pwm_capture.md
Name: bb_pwm_capture

Overview:
- Receive-side counterpart of the motor PWM generator. Measures the high time of an incoming PWM/RC pulse train (receiver channel or loop-back of an ESC line) in clk cycles.
- Emits each accepted measurement as a 16-bit speed word with a one-cycle strobe. The output matches the generator's speed_in/speed_oe convention, so the two blocks can connect directly.
- Also reports period and signal-loss status for the flight-control failsafe.

Parameters:
- MIN_SPEED, 256, smallest accepted high width (cycles); shorter pulses are glitches.
- MAX_SPEED, 65535, largest accepted high width (cycles); longer pulses are rejected.
- TIMEOUT, 1000000, cycles without any detected edge before lost asserts.
- TO_WIDTH, 20, width of the timeout counter; must satisfy 2^TO_WIDTH > TIMEOUT.
- STATE_WIDTH, 3, state register width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pwm_in  in  1  asynchronous PWM input pin
- speed_out  out  16  last accepted high width, in cycles
- speed_oe  out  1  one-cycle strobe: speed_out updated
- period_out  out  16  last rise-to-rise period, in cycles (saturating)
- lost  out  1  no valid signal present
- glitch_cnt  out  8  saturating count of rejected pulses
- busy  out  1  high while a pulse is being measured (state HIGH)

Behaviour:
- Reset values: speed_out=MIN_SPEED, speed_oe=0, period_out=0, lost=1, glitch_cnt=0, state=WAIT_LOW, all counters 0.
- Sync/edge detect:
  - pwm_in passes through 2 flops (s1, s2); s3 holds the previous s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - No other use of raw pwm_in.
- State machine:
  - WAIT_LOW: wait for s2==0, then go to WAIT_RISE. This discards any partial pulse after reset or loss.
  - WAIT_RISE: on rise, width_cnt<=1 and go to HIGH.
  - HIGH: width_cnt increments each cycle, saturating at 16'hFFFF. On fall, apply the accept/reject rule below, then go to LOW.
  - LOW: on rise, width_cnt<=1 and go to HIGH.
- Accept/reject on fall:
  - Accept when MIN_SPEED <= width_cnt <= MAX_SPEED: speed_out<=width_cnt, speed_oe<=1 for one cycle, lost<=0.
  - Reject otherwise: glitch_cnt increments (saturating at 255); speed_out holds.
- Width measurement: a pin held high for N consecutive clk-synchronous cycles yields width N. speed_oe rises at the 3rd clk edge after the edge at which pwm_in fell.
- Period:
  - per_cnt increments every cycle, saturating at 16'hFFFF.
  - On each rise in LOW: period_out<=per_cnt, then per_cnt<=1.
  - The first rise after WAIT_RISE only restarts per_cnt; period_out is not updated.
- Timeout:
  - to_cnt clears on any rise/fall and increments otherwise.
  - When to_cnt reaches TIMEOUT in any state except WAIT_LOW: lost<=1, go to WAIT_LOW, to_cnt<=0.
  - Timeout wins over a same-cycle edge.
  - speed_out holds its last value; the consumer decides failsafe from lost.
- Simultaneous events: a rise and a fall cannot occur in the same cycle. A rise detected on the same cycle as a fall-accept is handled next cycle (minimum low time 1 cycle).
- Reset mid-pulse: everything returns to reset values; the next reported pulse must be a complete one.
- busy = (state==HIGH).

Optional Feature:
- Macro: BB_PWM_CAPTURE_AVG_EN.
- Defined:
  - Accepted widths enter a 4-deep shift window.
  - speed_out = (sum of window)>>2 using an 18-bit sum; speed_oe is delayed one extra cycle.
  - speed_oe is suppressed until 4 accepts have occurred since reset or since the last lost assertion; the window flushes when lost asserts.
- Undefined: raw width path as described above, no extra latency.

Decomposition:
- Package bb_pwm_pkg:
  - State encoding: WAIT_LOW=0, WAIT_RISE=1, HIGH=2, LOW=3.
  - Shared MIN_SPEED/MAX_SPEED defaults and the 16-bit speed word width, also used by bb_pwm.
- One sub-module, bb_pwm_sync_edge: the 2-flop synchronizer plus s3 register, outputting level, rise and fall.

Test Plan:
- Reset, pwm_in=0, then high 1000 cycles / low 19000, repeated 3 times:
  - speed_out=1000 on each pulse; speed_oe pulses 3 edges after each fall.
  - period_out=20000 from the 2nd rise; lost drops after the 1st accept.
- Pulse high 100 cycles (<MIN_SPEED):
  - no speed_oe; glitch_cnt 0->1; speed_out unchanged.
- pwm_in high at reset release for 500 cycles, then normal 1200-cycle pulses:
  - the first partial pulse is not reported; the first speed_out is 1200.
- After valid pulses, hold pwm_in low for TIMEOUT=5000 (override):
  - lost=1 exactly 5000 cycles after the last synchronized edge; speed_out holds.
- Assert rst for 1 cycle in the middle of a 2000-cycle high:
  - all outputs return to reset values; that pulse is never reported.
- With BB_PWM_CAPTURE_AVG_EN, widths 1000, 1004, 1008, 1012:
  - no strobe for the first 3 accepts; 4th strobe with speed_out=1006.
